uart_axi_lite_ctrl: RTL and testbench
=====================================

// Module: uart_axi_lite_ctrl
// PURPOSE
//  AXI-lite UART peripheral with runtime baud divisor, 5-8 data bits, optional parity, 1/2 stop bits.
//  TX and RX are buffered by parametrised FIFOs; sticky error flags and a level interrupt are provided.
//  Sits on the SoC AXI-lite bus as a drop-in successor to the single-byte UART slave.
// PARAMETERS
//  DATA_BITS    8    frame data width, legal 5..8; unused upper bits read 0
//  FIFO_DEPTH   16   entries per TX/RX FIFO; power of 2, >= 2
//  DEFAULT_DIV  83   reset value of DIV (clk cycles per bit)
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous reset, active-high
//  axi_araddr   in   32  read address; only [3:2] decoded
//  axi_arvalid  in   1   / axi_arready out 1: read address handshake
//  axi_rdata    out  32  read data
//  axi_rresp    out  2   00 OKAY, 10 SLVERR
//  axi_rvalid   out  1   / axi_rready in 1: read data handshake
//  axi_awaddr   in   32  write address; only [3:2] decoded
//  axi_awvalid  in   1   / axi_awready out 1: write address handshake
//  axi_wdata    in   32  write data
//  axi_wvalid   in   1   / axi_wready out 1: write data handshake
//  b_valid      out  1   / b_ready in 1: write response handshake
//  b_response   out  2   00 OKAY, 10 SLVERR
//  urx          in   1   serial in (asynchronous, idle high)
//  utx          out  1   serial out (idle high)
//  irq          out  1   level interrupt
// BEHAVIOUR
//  Map: 0x0 DATA (rd pops RX, wr pushes TX); 0x4 STATUS; 0x8 CTRL; 0xC DIV[15:0].
//  CTRL: [0] par_en, [1] par_odd, [2] two_stop, [3] rx_ie, [4] tx_ie, [5] rx_flush, [6] tx_flush.
//    Bits [6:5] self-clear and read 0. Reset value 0.
//  STATUS: [0] rx_nempty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] tx_busy, [5] overrun,
//    [6] frame_err, [7] par_err, [15:8] rx_level. Writing 1 to [7:5] clears them; other bits RO.
//  Reset: utx=1, irq=0, b_valid=0, axi_rvalid=0, FIFOs empty, flags 0, DIV=DEFAULT_DIV, CTRL=0.
//    Reset mid-frame aborts the frame; utx=1 from the cycle after rst is sampled.
//  Write: awready=wready=!b_valid. awvalid&wvalid must be presented in the same cycle.
//    Accepted in that cycle; b_valid=1 the next cycle, held until b_ready.
//    Write DATA with TX full: byte dropped, b_response=10. Otherwise 00.
//  Read: arready=!axi_rvalid. axi_rvalid=1 the cycle after accept; rdata/rresp held until rready.
//    Read DATA with RX empty: rdata=0, rresp=10, no pop. DATA pop occurs at the accept cycle.
//  DIV: writes below 4 are stored as 4. A new value takes effect at the next frame start, not mid-frame.
//  TX FSM: IDLE->START->DATA(DATA_BITS, LSB first)->[PARITY]->STOP(1 or 2)->IDLE.
//    Starts when TX FIFO is non-empty. Each bit lasts DIV clks. Config is latched at START.
//    Parity: even = XOR of data bits; odd = its inverse. tx_busy=1 outside IDLE.
//  RX FSM: IDLE->START->DATA->[PARITY]->STOP->IDLE. urx is double-flopped. Sampling is mid-bit:
//    first sample at DIV/2 after the falling edge, then every DIV. Start sampled high returns to IDLE.
//    Stop sampled 0: byte discarded, frame_err=1, FSM waits for urx high before returning to IDLE.
//    Parity mismatch: byte pushed, par_err=1.
//    Push into full RX FIFO: byte dropped, overrun=1. A pop in the same cycle frees space: push accepted.
//  FIFOs: simultaneous push+pop keeps level unchanged. Flush empties the FIFO in 1 cycle.
//    tx_flush does not abort a frame already in progress.
//  irq = (rx_ie & rx_nempty) | (tx_ie & tx_empty) | overrun | frame_err | par_err. Registered, 1 clk latency.
// TESTING
//  Loopback utx->urx, DIV=8, CTRL=0, write DATA 0xA5 -> frame 10 bits x 8 clks, STATUS[0]=1, read DATA=0xA5.
//  CTRL par_en|par_odd|two_stop, send 0x03 -> parity bit=1, 2 stop bits on utx; RX reads 0x03, par_err=0.
//  Drive urx frame with wrong parity -> byte pushed, STATUS[7]=1, irq=1; write STATUS 0x80 -> flag 0, irq 0.
//  Loopback, FIFO_DEPTH=4, send 5 bytes, no reads -> rx_level=4, overrun=1, reads return first 4 bytes in order.
//  urx frame with stop=0 -> no push, frame_err=1. Read DATA while RX empty -> rdata=0, rresp=10.
//  Fill TX (DIV=1000) with FIFO_DEPTH+1 writes -> last b_response=10. Assert rst mid-frame -> utx=1, STATUS=0x04.

Source files
------------

// File: rtl/uart_axi_lite_ctrl.sv
// AXI-lite UART peripheral: programmable baud divisor, 5-8 data bits, optional
// parity, one or two stop bits, TX/RX FIFOs, sticky error flags and a level irq.
//
// Bus handshakes, valid/ready throughout: a transfer happens on a rising edge where
// both valid and ready are high. A write needs awvalid and wvalid together while
// awready/wready (= !b_valid) are high. b_valid then holds until b_ready is seen. A
// read is accepted when arvalid meets arready (= !axi_rvalid). axi_rvalid then holds
// rdata/rresp steady until axi_rready is seen.
//
// The byte being transmitted stays at the head of the TX FIFO until its last stop
// bit ends. tx_empty therefore means "nothing left to send".
module uart_axi_lite_ctrl #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 83
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] axi_araddr,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    input  logic [31:0] axi_awaddr,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic        b_valid,
    input  logic        b_ready,
    output logic [1:0]  b_response,
    input  logic        urx,
    output logic        utx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_t;

    // Configuration and sticky flags
    logic [4:0]  ctrl;
    logic [15:0] div;
    logic        overrun, frame_err, par_err;

    // FIFO storage and pointers
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [CW-1:0] tx_count, rx_count;
    logic tx_full, tx_empty, rx_full, rx_nempty;

    // Bus decode strobes
    logic       wr_fire, rd_fire;
    logic [1:0] wr_sel, rd_sel;
    logic       tx_push, rx_pop, tx_flush, rx_flush;
    logic [2:0] flag_clr;
    logic [31:0] rd_word, status_word;
    logic [1:0]  rd_resp;

    // TX engine
    tx_state_t tx_state, tx_state_next;
    logic [15:0] tx_cnt, tx_div_q;
    logic [2:0]  tx_idx;
    logic [DATA_BITS-1:0] tx_shreg;
    logic tx_par_en, tx_par_bit, tx_stop2, tx_hold;
    logic tx_tick, tx_start, tx_pop, tx_busy;

    // RX engine
    rx_state_t rx_state, rx_state_next;
    logic rx_meta, rx_sync;
    logic [15:0] rx_cnt, rx_div_q;
    logic [2:0]  rx_idx;
    logic [DATA_BITS-1:0] rx_shreg;
    logic rx_par_en, rx_par_odd, rx_par_bad;
    logic rx_tick, rx_push, rx_ferr, rx_push_ok, overrun_set;

    logic unused_bits;
    assign unused_bits = ^{axi_araddr[31:4], axi_araddr[1:0], axi_awaddr[31:4],
                           axi_awaddr[1:0], axi_wdata[31:16]};

    assign axi_awready = !b_valid;
    assign axi_wready  = !b_valid;
    assign axi_arready = !axi_rvalid;
    assign wr_fire  = axi_awvalid && axi_wvalid && !b_valid;
    assign rd_fire  = axi_arvalid && !axi_rvalid;
    assign wr_sel   = axi_awaddr[3:2];
    assign rd_sel   = axi_araddr[3:2];

    assign tx_full   = (tx_count == CW'(FIFO_DEPTH));
    assign tx_empty  = (tx_count == '0);
    assign rx_full   = (rx_count == CW'(FIFO_DEPTH));
    assign rx_nempty = (rx_count != '0);

    assign tx_push  = wr_fire && (wr_sel == 2'd0) && !tx_full;
    assign rx_pop   = rd_fire && (rd_sel == 2'd0) && rx_nempty;
    assign tx_flush = wr_fire && (wr_sel == 2'd2) && axi_wdata[6];
    assign rx_flush = wr_fire && (wr_sel == 2'd2) && axi_wdata[5];
    assign flag_clr = (wr_fire && wr_sel == 2'd1) ? axi_wdata[7:5] : 3'b000;

    // A pop in the same cycle frees the slot the incoming byte needs
    assign rx_push_ok  = rx_push && (!rx_full || rx_pop);
    assign overrun_set = rx_push && rx_full && !rx_pop;

    assign tx_busy = (tx_state != TX_IDLE);
    assign status_word = {16'd0, 8'(rx_count), par_err, frame_err, overrun, tx_busy,
                          tx_full, tx_empty, rx_full, rx_nempty};

    // Control, divisor and sticky error flags; a new event wins over a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl      <= 5'd0;
            div       <= 16'(DEFAULT_DIV);
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            if (wr_fire && wr_sel == 2'd2) ctrl <= axi_wdata[4:0];
            if (wr_fire && wr_sel == 2'd3) div <= (axi_wdata[15:0] < 16'd4) ? 16'd4 : axi_wdata[15:0];
            overrun   <= overrun_set | (overrun & !flag_clr[0]);
            frame_err <= rx_ferr | (frame_err & !flag_clr[1]);
            par_err   <= (rx_push & rx_par_bad) | (par_err & !flag_clr[2]);
        end
    end

    // Write response channel: DATA write into a full TX FIFO is dropped with SLVERR
    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid    <= 1'b0;
            b_response <= 2'b00;
        end else if (wr_fire) begin
            b_valid    <= 1'b1;
            b_response <= (wr_sel == 2'd0 && tx_full) ? 2'b10 : 2'b00;
        end else if (b_ready) begin
            b_valid <= 1'b0;
        end
    end

    // Read data selection for the register being accepted this cycle
    always_comb begin
        rd_word = 32'd0;
        rd_resp = 2'b00;
        case (rd_sel)
            2'd0: begin
                if (rx_nempty) rd_word = 32'(rx_mem[rx_rd]);
                else           rd_resp = 2'b10;
            end
            2'd1:    rd_word = status_word;
            2'd2:    rd_word = {27'd0, ctrl};
            default: rd_word = {16'd0, div};
        endcase
    end

    // Read data channel: capture on accept, hold until rready
    always_ff @(posedge clk) begin
        if (rst) begin
            axi_rvalid <= 1'b0;
            axi_rdata  <= 32'd0;
            axi_rresp  <= 2'b00;
        end else if (rd_fire) begin
            axi_rvalid <= 1'b1;
            axi_rdata  <= rd_word;
            axi_rresp  <= rd_resp;
        end else if (axi_rready) begin
            axi_rvalid <= 1'b0;
        end
    end

    // FIFO storage writes
    always_ff @(posedge clk) begin
        if (tx_push)    tx_mem[tx_wr] <= axi_wdata[DATA_BITS-1:0];
        if (rx_push_ok) rx_mem[rx_wr] <= rx_shreg;
    end

    // TX FIFO pointers and level; flush wins over everything
    always_ff @(posedge clk) begin
        if (rst || tx_flush) begin
            tx_wr <= '0; tx_rd <= '0; tx_count <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + AW'(1);
            if (tx_pop)  tx_rd <= tx_rd + AW'(1);
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
        end
    end

    // RX FIFO pointers and level; flush wins over everything
    always_ff @(posedge clk) begin
        if (rst || rx_flush) begin
            rx_wr <= '0; rx_rd <= '0; rx_count <= '0;
        end else begin
            if (rx_push_ok) rx_wr <= rx_wr + AW'(1);
            if (rx_pop)     rx_rd <= rx_rd + AW'(1);
            rx_count <= rx_count + CW'(rx_push_ok) - CW'(rx_pop);
        end
    end

    // Registered interrupt
    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= (ctrl[3] & rx_nempty) | (ctrl[4] & tx_empty) | overrun | frame_err | par_err;
    end

    // TX state register
    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_state_next;
    end

    assign tx_tick = (tx_cnt == 16'd0);

    // TX next state, line level and FIFO strobes
    always_comb begin
        tx_state_next = tx_state;
        tx_start      = 1'b0;
        tx_pop        = 1'b0;
        utx           = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_start      = 1'b1;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                utx = 1'b0;
                if (tx_tick) tx_state_next = TX_DATA;
            end
            TX_DATA: begin
                utx = tx_shreg[0];
                if (tx_tick && tx_idx == LAST_BIT) tx_state_next = tx_par_en ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                utx = tx_par_bit;
                if (tx_tick) tx_state_next = TX_STOP;
            end
            TX_STOP: begin
                if (tx_tick && !tx_stop2) begin
                    tx_state_next = TX_IDLE;
                    tx_pop        = tx_hold && !tx_flush;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // TX datapath: latch byte and config at frame start, then bit timing and shifting
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt <= 16'd0; tx_div_q <= 16'd0; tx_idx <= 3'd0; tx_shreg <= '0;
            tx_par_en <= 1'b0; tx_par_bit <= 1'b0; tx_stop2 <= 1'b0; tx_hold <= 1'b0;
        end else begin
            if (tx_flush)      tx_hold <= 1'b0;
            else if (tx_start) tx_hold <= 1'b1;
            else if (tx_pop)   tx_hold <= 1'b0;
            if (tx_start) begin
                tx_shreg   <= tx_mem[tx_rd];
                tx_div_q   <= div;
                tx_cnt     <= div - 16'd1;
                tx_idx     <= 3'd0;
                tx_par_en  <= ctrl[0];
                tx_par_bit <= (^tx_mem[tx_rd]) ^ ctrl[1];
                tx_stop2   <= ctrl[2];
            end else if (tx_state != TX_IDLE) begin
                if (tx_tick) begin
                    tx_cnt <= tx_div_q - 16'd1;
                    if (tx_state == TX_DATA) begin
                        tx_shreg <= tx_shreg >> 1;
                        tx_idx   <= tx_idx + 3'd1;
                    end
                    if (tx_state == TX_STOP) tx_stop2 <= 1'b0;
                end else begin
                    tx_cnt <= tx_cnt - 16'd1;
                end
            end
        end
    end

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= urx;
            rx_sync <= rx_meta;
        end
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_state_next;
    end

    assign rx_tick = (rx_cnt == 16'd0);

    // RX next state and push/frame-error strobes
    always_comb begin
        rx_state_next = rx_state;
        rx_push       = 1'b0;
        rx_ferr       = 1'b0;
        case (rx_state)
            RX_IDLE:   if (!rx_sync) rx_state_next = RX_START;
            RX_START:  if (rx_tick) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_tick && rx_idx == LAST_BIT) rx_state_next = rx_par_en ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_tick) rx_state_next = RX_STOP;
            RX_STOP: begin
                if (rx_tick) begin
                    rx_push       = rx_sync;
                    rx_ferr       = !rx_sync;
                    rx_state_next = rx_sync ? RX_IDLE : RX_WAIT;
                end
            end
            RX_WAIT:   if (rx_sync) rx_state_next = RX_IDLE;
            default:   rx_state_next = RX_IDLE;
        endcase
    end

    // RX datapath: half-bit delay to the start sample, then one sample per bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt <= 16'd0; rx_div_q <= 16'd0; rx_idx <= 3'd0; rx_shreg <= '0;
            rx_par_en <= 1'b0; rx_par_odd <= 1'b0; rx_par_bad <= 1'b0;
        end else if (rx_state == RX_IDLE) begin
            if (!rx_sync) begin
                rx_div_q   <= div;
                rx_cnt     <= (div >> 1) - 16'd1;
                rx_par_en  <= ctrl[0];
                rx_par_odd <= ctrl[1];
                rx_par_bad <= 1'b0;
            end
        end else if (rx_tick) begin
            rx_cnt <= rx_div_q - 16'd1;
            case (rx_state)
                RX_START: rx_idx <= 3'd0;
                RX_DATA: begin
                    rx_shreg <= {rx_sync, rx_shreg[DATA_BITS-1:1]};
                    rx_idx   <= rx_idx + 3'd1;
                end
                RX_PARITY: rx_par_bad <= rx_sync ^ (^rx_shreg) ^ rx_par_odd;
                default: ;
            endcase
        end else begin
            rx_cnt <= rx_cnt - 16'd1;
        end
    end

endmodule

// File: tb/tb_uart_axi_lite_ctrl.sv
// Self-checking bench for uart_axi_lite_ctrl (built with a 4-entry FIFO).
module tb_uart_axi_lite_ctrl;
    localparam int DEPTH   = 4;
    localparam int DEF_DIV = 83;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] axi_araddr, axi_awaddr, axi_wdata, axi_rdata;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic [1:0]  axi_rresp, b_response;
    logic        b_valid, b_ready;
    logic        urx, utx, irq;
    logic        loop_en, drv_rx;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } reg_vec_t;
    reg_vec_t tbl[9];

    assign urx = loop_en ? utx : drv_rx;

    // Clock
    always #5 clk = ~clk;

    uart_axi_lite_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DEF_DIV)) dut (
        .clk(clk), .rst(rst),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .b_valid(b_valid), .b_ready(b_ready), .b_response(b_response),
        .urx(urx), .utx(utx), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timed_out(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Drivers: called and returning at posedge+1
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
        int n;
        axi_awaddr = addr; axi_wdata = data; axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        n = 0;
        while (!(axi_awready && axi_wready) && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        n = 0;
        while (!b_valid && n < 100) begin @(posedge clk); #1; n++; end
        if (!b_valid) timed_out("b_valid");
        resp = b_response;
        b_ready = 1'b1;
        @(posedge clk); #1;
        b_ready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        axi_araddr = addr; axi_arvalid = 1'b1;
        n = 0;
        while (!axi_arready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
        n = 0;
        while (!axi_rvalid && n < 100) begin @(posedge clk); #1; n++; end
        if (!axi_rvalid) timed_out("rvalid");
        data = axi_rdata; resp = axi_rresp;
        axi_rready = 1'b1;
        @(posedge clk); #1;
        axi_rready = 1'b0;
    endtask

    task automatic write_ok(input string name, input logic [31:0] addr, input logic [31:0] data);
        logic [1:0] r;
        axi_write(addr, data, r);
        check({name, "_bresp"}, 32'(r), 32'd0);
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(addr, d, r);
        check(name, d, exp);
    endtask

    // Scoreboard: pop the oldest expected byte and compare with a DATA read
    task automatic read_expect_byte(input string name);
        logic [31:0] d;
        logic [1:0]  r;
        logic [7:0]  e;
        axi_read(32'h0, d, r);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got byte 0x%0h, expected none", name, d);
        end else begin
            e = exp_q.pop_front();
            check(name, d, {24'd0, e});
            check({name, "_rresp"}, 32'(r), 32'd0);
        end
    endtask

    // Serial monitor: find the start bit, then sample each bit mid-way
    task automatic capture_frame(input int div, input int nbits, output logic [15:0] bits);
        int n;
        bits = '0;
        n = 0;
        while (utx !== 1'b0 && n < 3000) begin @(posedge clk); #1; n++; end
        if (utx !== 1'b0) begin
            timed_out("frame_start");
        end else begin
            repeat (div / 2) @(posedge clk);
            #1;
            bits[0] = utx;
            for (int i = 1; i < nbits; i++) begin
                repeat (div) @(posedge clk);
                #1;
                bits[i] = utx;
            end
        end
    endtask

    // Serial driver for urx
    task automatic drive_frame(input int div, input logic [7:0] data, input logic use_par,
                               input logic par_bit, input logic stop_bit);
        drv_rx = 1'b0;
        repeat (div) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            drv_rx = data[i];
            repeat (div) @(posedge clk);
            #1;
        end
        if (use_par) begin
            drv_rx = par_bit;
            repeat (div) @(posedge clk);
            #1;
        end
        drv_rx = stop_bit;
        repeat (div) @(posedge clk);
        #1;
        drv_rx = 1'b1;
        repeat (2 * div) @(posedge clk);
        #1;
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [15:0] bits;
        logic [9:0]  exp10;
        logic [11:0] exp12;
        logic [7:0]  b;

        tbl[0] = '{32'hC, 32'h0000_0008, 32'h0000_0008, 1'b0};
        tbl[1] = '{32'hC, 32'h0000_0002, 32'h0000_0004, 1'b0};
        tbl[2] = '{32'hC, 32'h0000_0000, 32'h0000_0004, 1'b0};
        tbl[3] = '{32'hC, 32'hABCD_1234, 32'h0000_1234, 1'b0};
        tbl[4] = '{32'h8, 32'hFFFF_FFFF, 32'h0000_001F, 1'b1};
        tbl[5] = '{32'h8, 32'h0000_0015, 32'h0000_0015, 1'b1};
        tbl[6] = '{32'h8, 32'h0000_0008, 32'h0000_0008, 1'b0};
        tbl[7] = '{32'h8, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[8] = '{32'hC, 32'h0000_0008, 32'h0000_0008, 1'b0};

        // Reset
        rst = 1'b1; loop_en = 1'b0; drv_rx = 1'b1;
        axi_araddr = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
        axi_awaddr = '0; axi_awvalid = 1'b0; axi_wdata = '0; axi_wvalid = 1'b0; b_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_utx", 32'(utx), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_bvalid", 32'(b_valid), 32'd0);
        check("rst_rvalid", 32'(axi_rvalid), 32'd0);
        read_check("rst_status", 32'h4, 32'h0000_0004);
        read_check("rst_ctrl", 32'h8, 32'h0);
        read_check("rst_div", 32'hC, 32'(DEF_DIV));
        axi_read(32'h0, d, r);
        check("empty_rdata", d, 32'h0);
        check("empty_rresp", 32'(r), 32'h2);

        // Register write/readback vectors
        for (int i = 0; i < 9; i++) begin
            write_ok($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].wdata);
            read_check($sformatf("tbl%0d_rd", i), tbl[i].addr, tbl[i].exp_rd);
            check($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].exp_irq));
        end

        // Loopback 0xA5, 8N1, DIV=8
        loop_en = 1'b1;
        exp_q.push_back(8'hA5);
        fork
            axi_write(32'h0, 32'h0000_00A5, r);
            capture_frame(8, 10, bits);
        join
        exp10 = {1'b1, 8'hA5, 1'b0};
        check("a5_bresp", 32'(r), 32'd0);
        check("a5_frame", 32'(bits[9:0]), 32'(exp10));
        repeat (20) @(posedge clk);
        #1;
        read_check("a5_status", 32'h4, 32'h0000_0105);
        read_expect_byte("a5_data");

        // Odd parity, two stop bits
        write_ok("ctrl_8o2", 32'h8, 32'h0000_0007);
        exp_q.push_back(8'h03);
        fork
            axi_write(32'h0, 32'h0000_0003, r);
            capture_frame(8, 12, bits);
        join
        exp12 = {2'b11, 1'b1, 8'h03, 1'b0};
        check("par_frame", 32'(bits[11:0]), 32'(exp12));
        repeat (10) @(posedge clk);
        #1;
        read_expect_byte("par_data");
        read_check("par_status", 32'h4, 32'h0000_0004);

        // Wrong parity on urx (even parity of 0x5A is 0, drive 1)
        loop_en = 1'b0;
        write_ok("ctrl_8e1", 32'h8, 32'h0000_0001);
        exp_q.push_back(8'h5A);
        drive_frame(8, 8'h5A, 1'b1, 1'b1, 1'b1);
        read_check("perr_status", 32'h4, 32'h0000_0185);
        check("perr_irq", 32'(irq), 32'd1);
        write_ok("perr_clr", 32'h4, 32'h0000_0080);
        read_check("perr_cleared", 32'h4, 32'h0000_0105);
        check("perr_irq_clr", 32'(irq), 32'd0);
        read_expect_byte("perr_data");

        // Stop bit low: byte discarded, frame error
        write_ok("ctrl_8n1", 32'h8, 32'h0000_0000);
        drive_frame(8, 8'h33, 1'b0, 1'b0, 1'b0);
        read_check("ferr_status", 32'h4, 32'h0000_0044);
        check("ferr_irq", 32'(irq), 32'd1);
        axi_read(32'h0, d, r);
        check("ferr_rdata", d, 32'h0);
        check("ferr_rresp", 32'(r), 32'h2);
        write_ok("ferr_clr", 32'h4, 32'h0000_0040);
        read_check("ferr_cleared", 32'h4, 32'h0000_0004);

        // Overrun: five bytes into a four-entry RX FIFO
        loop_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b = 8'(8'h11 * (i + 1));
            if (i < DEPTH) exp_q.push_back(b);
            write_ok($sformatf("ovr_wr%0d", i), 32'h0, {24'd0, b});
            repeat (100) @(posedge clk);
            #1;
        end
        read_check("ovr_status", 32'h4, 32'h0000_0427);
        check("ovr_irq", 32'(irq), 32'd1);
        for (int i = 0; i < DEPTH; i++) read_expect_byte($sformatf("ovr_data%0d", i));
        read_check("ovr_status_drained", 32'h4, 32'h0000_0024);
        write_ok("ovr_clr", 32'h4, 32'h0000_0020);
        read_check("ovr_cleared", 32'h4, 32'h0000_0004);
        check("ovr_queue_empty", 32'(exp_q.size()), 32'd0);

        // Fill TX at a slow rate: the last write is refused
        loop_en = 1'b0;
        write_ok("slow_div", 32'hC, 32'd1000);
        for (int i = 0; i <= DEPTH; i++) begin
            axi_write(32'h0, 32'h40 + 32'(i), r);
            check($sformatf("fill_bresp%0d", i), 32'(r), (i < DEPTH) ? 32'd0 : 32'd2);
        end
        read_check("fill_status", 32'h4, 32'h0000_0018);

        // Reset in the middle of a frame
        repeat (1500) @(posedge clk);
        #1;
        check("mid_frame_busy", 32'(dut.tx_busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_utx", 32'(utx), 32'd1);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_utx_idle", 32'(utx), 32'd1);
        read_check("rst_mid_status", 32'h4, 32'h0000_0004);
        read_check("rst_mid_div", 32'hC, 32'(DEF_DIV));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
